// File: rtl/cdr_trigger_pkg.sv
// Shared types for the 8b/10b trigger engine: trigger source, FSM states,
// the decoded-symbol record and the per-position compare rule.
package cdr_trigger_pkg;

    typedef enum logic [1:0] {
        MODE_PATTERN  = 2'd0,
        MODE_DISP_ERR = 2'd1,
        MODE_SYM_ERR  = 2'd2,
        MODE_ANY_ERR  = 2'd3
    } cdr_trig_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_DONE    = 2'd3
    } cdr_trig_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       is_ctl;
        logic       valid;
    } cdr_sym_t;

    localparam cdr_sym_t SYM_EMPTY = '{data: 8'h00, is_ctl: 1'b0, valid: 1'b0};

    // A don't-care position always passes; a checked one needs a real symbol
    // with the right byte and the right K/D type.
    function automatic logic sym_matches(input cdr_sym_t sym,
                                         input logic [7:0] pat,
                                         input logic pat_ctl,
                                         input logic care);
        return (!care) || (sym.valid && (sym.data == pat) && (sym.is_ctl == pat_ctl));
    endfunction

endpackage

// File: rtl/cdr_8b10b_align_compare.sv
// Masked compare of one PATTERN_LEN-symbol window against the configured
// pattern. window[0] is the earliest symbol and lines up with pattern[0].
module cdr_8b10b_align_compare
    import cdr_trigger_pkg::*;
#(
    parameter int PATTERN_LEN = 10
)(
    input  cdr_sym_t [PATTERN_LEN-1:0]   window,
    input  logic     [8*PATTERN_LEN-1:0] cfg_pattern,
    input  logic     [PATTERN_LEN-1:0]   cfg_type,
    input  logic     [PATTERN_LEN-1:0]   cfg_mask,
    output logic                         match
);

    // All positions must pass; an all-zero mask is treated as "never match".
    always_comb begin
        match = |cfg_mask;
        for (int i = 0; i < PATTERN_LEN; i++) begin
            match = match & sym_matches(window[i], cfg_pattern[8*i +: 8],
                                        cfg_type[i], cfg_mask[i]);
        end
    end

endmodule

// File: rtl/cdr_8b10b_pattern_trigger.sv
// 8b/10b trigger engine. Symbols are captured, compared at every lane
// alignment against a window of history plus the current beat (or checked
// for error flags), registered as a per-lane hit vector, and then fed to the
// arm/holdoff/one-shot FSM that produces a one-cycle trigger pulse.
// Latency: trig_out rises two rx_clk edges after the edge that captures the
// final symbol.
module cdr_8b10b_pattern_trigger
    import cdr_trigger_pkg::*;
#(
    parameter  int LANES        = 4,
    parameter  int PATTERN_LEN  = 10,
    parameter  int HOLDOFF_BITS = 16,
    parameter  int COUNT_BITS   = 32,
    localparam int LANE_W       = (LANES > 1) ? $clog2(LANES) : 1
)(
    input  logic                     rx_clk,
    input  logic                     rx_rst,
    input  logic                     sym_valid,
    input  logic [8*LANES-1:0]       sym_data,
    input  logic [LANES-1:0]         sym_is_ctl,
    input  logic [LANES-1:0]         sym_disp_err,
    input  logic [LANES-1:0]         sym_err,
    input  logic                     sym_locked,
    input  logic [1:0]               cfg_mode,
    input  logic [8*PATTERN_LEN-1:0] cfg_pattern,
    input  logic [PATTERN_LEN-1:0]   cfg_type,
    input  logic [PATTERN_LEN-1:0]   cfg_mask,
    input  logic                     cfg_arm,
    input  logic                     cfg_oneshot,
    input  logic [HOLDOFF_BITS-1:0]  cfg_holdoff,
    output logic                     trig_out,
    output logic [LANE_W-1:0]        trig_lane,
    output logic                     armed,
    output logic [COUNT_BITS-1:0]    hit_count
);

    localparam int HIST_LEN   = PATTERN_LEN - 1;
    localparam int HIST_DEPTH = (HIST_LEN > 0) ? HIST_LEN : 1;
    localparam int WIN_LEN    = HIST_LEN + LANES;

    cdr_sym_t [LANES-1:0] cap_sym_r;
    logic     [LANES-1:0] cap_disp_r;
    logic     [LANES-1:0] cap_err_r;
    logic                 cap_valid_r;
    logic                 cap_locked_r;

    cdr_sym_t             hist_r [HIST_DEPTH];
    cdr_sym_t             win_s  [WIN_LEN];

    logic     [LANES-1:0] match_s;
    logic     [LANES-1:0] hit_s;
    logic     [LANES-1:0] hit_vec_r;
    logic                 hit_any_s;
    logic     [LANE_W-1:0] hit_lane_s;

    cdr_trig_state_t         state_r;
    logic [HOLDOFF_BITS-1:0] holdoff_ctr_r;

    // Capture the incoming beat; a lane is only usable when valid and locked.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            cap_sym_r    <= '0;
            cap_disp_r   <= '0;
            cap_err_r    <= '0;
            cap_valid_r  <= 1'b0;
            cap_locked_r <= 1'b0;
        end else begin
            cap_valid_r  <= sym_valid & sym_locked;
            cap_locked_r <= sym_locked;
            cap_disp_r   <= sym_disp_err;
            cap_err_r    <= sym_err;
            for (int k = 0; k < LANES; k++) begin
                cap_sym_r[k].data   <= sym_data[8*k +: 8];
                cap_sym_r[k].is_ctl <= sym_is_ctl[k];
                cap_sym_r[k].valid  <= sym_valid & sym_locked;
            end
        end
    end

    // Time-ordered window: history (oldest first) followed by the captured lanes.
    always_comb begin
        for (int i = 0; i < WIN_LEN; i++) begin
            win_s[i] = SYM_EMPTY;
        end
        for (int i = 0; i < HIST_LEN; i++) begin
            win_s[i] = hist_r[i];
        end
        for (int k = 0; k < LANES; k++) begin
            win_s[HIST_LEN + k] = cap_sym_r[k];
        end
    end

    // Keep the newest HIST_LEN symbols; loss of lock invalidates all of them.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_r[i] <= SYM_EMPTY;
            end
        end else if (!cap_locked_r) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_r[i].valid <= 1'b0;
            end
        end else if (cap_valid_r) begin
            for (int i = 0; i < HIST_LEN; i++) begin
                hist_r[i] <= win_s[LANES + i];
            end
        end else begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_r[i] <= hist_r[i];
            end
        end
    end

    // One comparator per alignment: alignment k ends the pattern on lane k.
    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_align
            cdr_sym_t [PATTERN_LEN-1:0] window_s;

            // Slice this alignment's PATTERN_LEN symbols out of the window.
            always_comb begin
                for (int i = 0; i < PATTERN_LEN; i++) begin
                    window_s[i] = win_s[g + i];
                end
            end

            cdr_8b10b_align_compare #(
                .PATTERN_LEN (PATTERN_LEN)
            ) u_cmp (
                .window      (window_s),
                .cfg_pattern (cfg_pattern),
                .cfg_type    (cfg_type),
                .cfg_mask    (cfg_mask),
                .match       (match_s[g])
            );
        end
    endgenerate

    // Select the trigger source per lane; invalid or unlocked beats never hit.
    always_comb begin
        hit_s = '0;
        case (cdr_trig_mode_t'(cfg_mode))
            MODE_PATTERN:  hit_s = match_s;
            MODE_DISP_ERR: hit_s = cap_disp_r;
            MODE_SYM_ERR:  hit_s = cap_err_r;
            MODE_ANY_ERR:  hit_s = cap_disp_r | cap_err_r;
            default:       hit_s = '0;
        endcase
        hit_s = hit_s & {LANES{cap_valid_r}};
    end

    // Stage 1: register the per-alignment hit vector.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            hit_vec_r <= '0;
        end else begin
            hit_vec_r <= hit_s;
        end
    end

    // Lowest hitting lane wins when several alignments fire together.
    always_comb begin
        hit_lane_s = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (hit_vec_r[k]) begin
                hit_lane_s = LANE_W'(k);
            end else begin
                hit_lane_s = hit_lane_s;
            end
        end
    end

    assign hit_any_s = |hit_vec_r;

    // Stage 2: arm/holdoff/one-shot FSM with registered pulse, lane and count.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_r       <= ST_IDLE;
            holdoff_ctr_r <= '0;
            trig_out      <= 1'b0;
            trig_lane     <= '0;
            armed         <= 1'b0;
            hit_count     <= '0;
        end else begin
            trig_out  <= 1'b0;
            trig_lane <= '0;
            if (!cfg_arm) begin
                state_r <= ST_IDLE;
                armed   <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r   <= ST_ARMED;
                        armed     <= 1'b1;
                        hit_count <= '0;
                    end
                    ST_ARMED: begin
                        if (hit_any_s) begin
                            trig_out  <= 1'b1;
                            trig_lane <= hit_lane_s;
                            if (hit_count != {COUNT_BITS{1'b1}}) begin
                                hit_count <= hit_count + COUNT_BITS'(1);
                            end
                            if (cfg_oneshot) begin
                                state_r <= ST_DONE;
                                armed   <= 1'b0;
                            end else if (cfg_holdoff == '0) begin
                                state_r <= ST_ARMED;
                                armed   <= 1'b1;
                            end else begin
                                state_r       <= ST_HOLDOFF;
                                armed         <= 1'b0;
                                holdoff_ctr_r <= cfg_holdoff;
                            end
                        end else begin
                            armed <= 1'b1;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (holdoff_ctr_r <= HOLDOFF_BITS'(1)) begin
                            state_r       <= ST_ARMED;
                            armed         <= 1'b1;
                            holdoff_ctr_r <= '0;
                        end else begin
                            holdoff_ctr_r <= holdoff_ctr_r - HOLDOFF_BITS'(1);
                        end
                    end
                    ST_DONE: begin
                        armed <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        armed   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cdr_8b10b_pattern_trigger.sv
// Directed bench for the 8b/10b trigger engine. A second instance with a
// 2-bit hit counter is used to observe counter saturation.
module tb_cdr_8b10b_pattern_trigger;

    localparam int LANES = 4;
    localparam int PLEN  = 10;
    localparam int HB    = 16;

    logic              rx_clk = 1'b0;
    logic              rx_rst;
    logic              sym_valid;
    logic [8*LANES-1:0] sym_data;
    logic [LANES-1:0]  sym_is_ctl;
    logic [LANES-1:0]  sym_disp_err;
    logic [LANES-1:0]  sym_err;
    logic              sym_locked;
    logic [1:0]        cfg_mode;
    logic [8*PLEN-1:0] cfg_pattern;
    logic [PLEN-1:0]   cfg_type;
    logic [PLEN-1:0]   cfg_mask;
    logic              cfg_arm;
    logic              cfg_oneshot;
    logic [HB-1:0]     cfg_holdoff;

    logic              trig_out;
    logic [1:0]        trig_lane;
    logic              armed;
    logic [31:0]       hit_count;
    logic              trig_out_s;
    logic [1:0]        trig_lane_s;
    logic              armed_s;
    logic [1:0]        hit_count_s;

    int total = 0;
    int bad   = 0;

    logic [7:0] seq_data [PLEN];
    logic       seq_ctl  [PLEN];
    int         pulse_idx[$];
    int         pulse_lane[$];
    int         sat_pulses;
    int         sat_last_lane;

    cdr_8b10b_pattern_trigger #(
        .LANES(LANES), .PATTERN_LEN(PLEN), .HOLDOFF_BITS(HB), .COUNT_BITS(32)
    ) dut (
        .rx_clk(rx_clk), .rx_rst(rx_rst), .sym_valid(sym_valid), .sym_data(sym_data),
        .sym_is_ctl(sym_is_ctl), .sym_disp_err(sym_disp_err), .sym_err(sym_err),
        .sym_locked(sym_locked), .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern),
        .cfg_type(cfg_type), .cfg_mask(cfg_mask), .cfg_arm(cfg_arm),
        .cfg_oneshot(cfg_oneshot), .cfg_holdoff(cfg_holdoff),
        .trig_out(trig_out), .trig_lane(trig_lane), .armed(armed), .hit_count(hit_count)
    );

    cdr_8b10b_pattern_trigger #(
        .LANES(LANES), .PATTERN_LEN(PLEN), .HOLDOFF_BITS(HB), .COUNT_BITS(2)
    ) dut_sat (
        .rx_clk(rx_clk), .rx_rst(rx_rst), .sym_valid(sym_valid), .sym_data(sym_data),
        .sym_is_ctl(sym_is_ctl), .sym_disp_err(sym_disp_err), .sym_err(sym_err),
        .sym_locked(sym_locked), .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern),
        .cfg_type(cfg_type), .cfg_mask(cfg_mask), .cfg_arm(cfg_arm),
        .cfg_oneshot(cfg_oneshot), .cfg_holdoff(cfg_holdoff),
        .trig_out(trig_out_s), .trig_lane(trig_lane_s), .armed(armed_s), .hit_count(hit_count_s)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic step();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic idle_inputs();
        sym_valid    = 1'b0;
        sym_data     = '0;
        sym_is_ctl   = '0;
        sym_disp_err = '0;
        sym_err      = '0;
        sym_locked   = 1'b1;
    endtask

    // Step n cycles, logging the step index and lane of every trigger pulse.
    task automatic run_count(input int n);
        pulse_idx.delete();
        pulse_lane.delete();
        sat_pulses = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (trig_out) begin
                pulse_idx.push_back(i);
                pulse_lane.push_back(int'(trig_lane));
            end
            if (trig_out_s) begin
                sat_pulses++;
                sat_last_lane = int'(trig_lane_s);
            end
        end
    endtask

    function automatic int pidx(input int n);
        return (n < pulse_idx.size()) ? pulse_idx[n] : -1;
    endfunction

    function automatic int plane(input int n);
        return (n < pulse_lane.size()) ? pulse_lane[n] : -1;
    endfunction

    // K28.5, D21.5 x4, D10.2 x5
    task automatic load_seq(input logic first_ctl);
        seq_data[0] = 8'hBC;
        seq_ctl[0]  = first_ctl;
        for (int i = 1; i < PLEN; i++) begin
            seq_data[i] = (i < 5) ? 8'hB5 : 8'h4A;
            seq_ctl[i]  = 1'b0;
        end
    endtask

    // Send seq[from..upto-1] starting on start_lane; unused lanes carry 0x00 data.
    task automatic send_seq(input int start_lane, input int from, input int upto);
        int pos;
        int lane0;
        pos   = from;
        lane0 = start_lane;
        while (pos < upto) begin
            sym_data   = '0;
            sym_is_ctl = '0;
            sym_valid  = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                if (l >= lane0 && pos < upto) begin
                    sym_data[8*l +: 8] = seq_data[pos];
                    sym_is_ctl[l]      = seq_ctl[pos];
                    pos++;
                end
            end
            lane0 = 0;
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rx_rst = 1'b1;
        idle_inputs();
        cfg_arm = 1'b0;
        step();
        step();
        total++; if (trig_out !== 1'b0) begin bad++; $display("FAIL reset_trig: got %0b expected 0", trig_out); end
        total++; if (trig_lane !== 2'd0) begin bad++; $display("FAIL reset_lane: got %0d expected 0", trig_lane); end
        total++; if (armed !== 1'b0) begin bad++; $display("FAIL reset_armed: got %0b expected 0", armed); end
        total++; if (hit_count !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", hit_count); end
        rx_rst = 1'b0;
        step();
        total++; if (armed !== 1'b0) begin bad++; $display("FAIL idle_unarmed: got %0b expected 0", armed); end
    endtask

    task automatic test_pattern_lane2();
        cfg_mode = 2'd0;
        cfg_arm  = 1'b1;
        step();
        total++; if (armed !== 1'b1) begin bad++; $display("FAIL arm_armed: got %0b expected 1", armed); end
        load_seq(1'b1);
        send_seq(1, 0, PLEN);
        run_count(6);
        total++; if (pulse_idx.size() !== 1) begin bad++; $display("FAIL lane2_pulses: got %0d expected 1", pulse_idx.size()); end
        total++; if (pidx(0) !== 2) begin bad++; $display("FAIL lane2_latency: got %0d expected 2", pidx(0)); end
        total++; if (plane(0) !== 2) begin bad++; $display("FAIL lane2_lane: got %0d expected 2", plane(0)); end
        total++; if (hit_count !== 32'd1) begin bad++; $display("FAIL lane2_count: got %0d expected 1", hit_count); end
    endtask

    task automatic test_pattern_span();
        load_seq(1'b1);
        send_seq(3, 0, PLEN);
        run_count(6);
        total++; if (pulse_idx.size() !== 1) begin bad++; $display("FAIL span_pulses: got %0d expected 1", pulse_idx.size()); end
        total++; if (pidx(0) !== 2) begin bad++; $display("FAIL span_latency: got %0d expected 2", pidx(0)); end
        total++; if (plane(0) !== 0) begin bad++; $display("FAIL span_lane: got %0d expected 0", plane(0)); end
        load_seq(1'b0);
        send_seq(3, 0, PLEN);
        run_count(6);
        total++; if (pulse_idx.size() !== 0) begin bad++; $display("FAIL type_nofire: got %0d expected 0", pulse_idx.size()); end
        total++; if (hit_count !== 32'd2) begin bad++; $display("FAIL span_count: got %0d expected 2", hit_count); end
    endtask

    task automatic test_disp_err();
        cfg_mode     = 2'd1;
        cfg_holdoff  = '0;
        sym_valid    = 1'b1;
        sym_disp_err = 4'b1010;
        step();
        idle_inputs();
        run_count(6);
        total++; if (pulse_idx.size() !== 1) begin bad++; $display("FAIL disp_pulses: got %0d expected 1", pulse_idx.size()); end
        total++; if (pidx(0) !== 2) begin bad++; $display("FAIL disp_latency: got %0d expected 2", pidx(0)); end
        total++; if (plane(0) !== 1) begin bad++; $display("FAIL disp_lane: got %0d expected 1", plane(0)); end
        total++; if (hit_count !== 32'd3) begin bad++; $display("FAIL disp_count: got %0d expected 3", hit_count); end
        sym_valid    = 1'b1;
        sym_locked   = 1'b0;
        sym_disp_err = 4'b1010;
        step();
        idle_inputs();
        run_count(6);
        total++; if (pulse_idx.size() !== 0) begin bad++; $display("FAIL unlocked_nofire: got %0d expected 0", pulse_idx.size()); end
    endtask

    task automatic test_holdoff();
        cfg_holdoff  = 16'd5;
        sym_valid    = 1'b1;
        sym_disp_err = 4'b0001;
        run_count(15);
        total++; if (pulse_idx.size() !== 3) begin bad++; $display("FAIL holdoff_pulses: got %0d expected 3", pulse_idx.size()); end
        total++; if (pidx(0) !== 3) begin bad++; $display("FAIL holdoff_first: got %0d expected 3", pidx(0)); end
        total++; if (pidx(1) !== 9) begin bad++; $display("FAIL holdoff_second: got %0d expected 9", pidx(1)); end
        total++; if (pidx(2) !== 15) begin bad++; $display("FAIL holdoff_third: got %0d expected 15", pidx(2)); end
        idle_inputs();
        run_count(8);
        cfg_holdoff  = 16'd0;
        sym_valid    = 1'b1;
        sym_disp_err = 4'b0001;
        run_count(8);
        total++; if (pulse_idx.size() !== 6) begin bad++; $display("FAIL nohold_pulses: got %0d expected 6", pulse_idx.size()); end
        total++; if (pidx(0) !== 3) begin bad++; $display("FAIL nohold_first: got %0d expected 3", pidx(0)); end
        total++; if (pidx(5) !== 8) begin bad++; $display("FAIL nohold_last: got %0d expected 8", pidx(5)); end
        idle_inputs();
        run_count(4);
    endtask

    task automatic test_oneshot();
        cfg_oneshot  = 1'b1;
        sym_valid    = 1'b1;
        sym_disp_err = 4'b0100;
        run_count(8);
        total++; if (pulse_idx.size() !== 1) begin bad++; $display("FAIL oneshot_pulses: got %0d expected 1", pulse_idx.size()); end
        total++; if (plane(0) !== 2) begin bad++; $display("FAIL oneshot_lane: got %0d expected 2", plane(0)); end
        total++; if (armed !== 1'b0) begin bad++; $display("FAIL oneshot_done: got %0b expected 0", armed); end
        idle_inputs();
        run_count(4);
        cfg_arm = 1'b0;
        step();
        cfg_arm = 1'b1;
        step();
        total++; if (hit_count !== 32'd0) begin bad++; $display("FAIL rearm_clear: got %0d expected 0", hit_count); end
        total++; if (armed !== 1'b1) begin bad++; $display("FAIL rearm_armed: got %0b expected 1", armed); end
        sym_valid    = 1'b1;
        sym_disp_err = 4'b0001;
        step();
        idle_inputs();
        run_count(5);
        total++; if (pulse_idx.size() !== 1) begin bad++; $display("FAIL rearm_pulses: got %0d expected 1", pulse_idx.size()); end
        total++; if (hit_count !== 32'd1) begin bad++; $display("FAIL rearm_count: got %0d expected 1", hit_count); end
    endtask

    task automatic test_reset_mid_pattern();
        cfg_oneshot = 1'b0;
        cfg_mode    = 2'd0;
        load_seq(1'b1);
        send_seq(2, 0, 6);
        rx_rst = 1'b1;
        #1;
        total++; if (hit_count !== 32'd0) begin bad++; $display("FAIL rst_async_count: got %0d expected 0", hit_count); end
        step();
        step();
        rx_rst = 1'b0;
        step();
        step();
        total++; if (armed !== 1'b1) begin bad++; $display("FAIL rst_rearmed: got %0b expected 1", armed); end
        send_seq(0, 6, PLEN);
        run_count(6);
        total++; if (pulse_idx.size() !== 0) begin bad++; $display("FAIL rst_nofire: got %0d expected 0", pulse_idx.size()); end
        send_seq(1, 0, PLEN);
        run_count(6);
        total++; if (pulse_idx.size() !== 1) begin bad++; $display("FAIL rst_recover: got %0d expected 1", pulse_idx.size()); end
    endtask

    task automatic test_saturation();
        cfg_mode    = 2'd1;
        cfg_holdoff = 16'd0;
        cfg_arm     = 1'b0;
        step();
        cfg_arm = 1'b1;
        step();
        total++; if (hit_count_s !== 2'd0) begin bad++; $display("FAIL sat_clear: got %0d expected 0", hit_count_s); end
        sym_valid    = 1'b1;
        sym_disp_err = 4'b1000;
        run_count(8);
        total++; if (sat_pulses !== 6) begin bad++; $display("FAIL sat_pulses: got %0d expected 6", sat_pulses); end
        total++; if (hit_count_s !== 2'd3) begin bad++; $display("FAIL sat_value: got %0d expected 3", hit_count_s); end
        idle_inputs();
        run_count(4);
        total++; if (pulse_idx.size() !== 2) begin bad++; $display("FAIL sat_tail: got %0d expected 2", pulse_idx.size()); end
        total++; if (sat_last_lane !== 3) begin bad++; $display("FAIL sat_lane: got %0d expected 3", sat_last_lane); end
        total++; if (hit_count_s !== 2'd3) begin bad++; $display("FAIL sat_hold: got %0d expected 3", hit_count_s); end
        total++; if (hit_count !== 32'd8) begin bad++; $display("FAIL wide_count: got %0d expected 8", hit_count); end
        total++; if (armed_s !== 1'b1) begin bad++; $display("FAIL sat_armed: got %0b expected 1", armed_s); end
    endtask

    initial begin
        sat_pulses    = 0;
        sat_last_lane = -1;
        cfg_mode      = 2'd0;
        cfg_type      = 10'h001;
        cfg_mask      = 10'h3FF;
        cfg_oneshot   = 1'b0;
        cfg_holdoff   = '0;
        load_seq(1'b1);
        for (int i = 0; i < PLEN; i++) begin
            cfg_pattern[8*i +: 8] = seq_data[i];
        end
        test_reset();
        test_pattern_lane2();
        test_pattern_span();
        test_disp_err();
        test_holdoff();
        test_oneshot();
        test_reset_mid_pattern();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
